// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RFILL = 2'd1,
    WRITE = 2'd2,
    WDONE = 2'd3
  } state_t;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int a_width, input int lines);
    return a_width - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Cache line storage: valid bits (resettable), tag and data arrays (not reset).
module dcache_store
  import dcache_pkg::*;
#(
  parameter int d_width = 8,
  parameter int a_width = 8,
  parameter int lines   = 4
) (
  input  logic                            i_clk,
  input  logic                            i_clr,
  input  logic                            i_clear,
  input  logic [idx_w(lines)-1:0]         i_rd_idx,
  output logic                            o_valid,
  output logic [tag_w(a_width,lines)-1:0] o_tag,
  output logic [d_width-1:0]              o_data,
  input  logic                            i_we,
  input  logic [idx_w(lines)-1:0]         i_wr_idx,
  input  logic [tag_w(a_width,lines)-1:0] i_wr_tag,
  input  logic [d_width-1:0]              i_wr_data
);

  localparam int IW = idx_w(lines);
  localparam int TW = tag_w(a_width, lines);

  logic [lines-1:0]   r_valid;
  logic [TW-1:0]      r_tag  [lines];
  logic [d_width-1:0] r_data [lines];

  always_ff @(posedge i_clk) begin
    if (i_clr || i_clear) r_valid <= '0;
    else if (i_we)        r_valid[i_wr_idx] <= 1'b1;
  end

  // A write hit rewrites the same tag, so fill and write-hit share one port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_valid = r_valid[i_rd_idx];
  assign o_tag   = r_tag[i_rd_idx];
  assign o_data  = r_data[i_rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through cache controller sequencing all data-RAM traffic.
// Handshake: cpu_rd/cpu_wr are held until odv=1; odv marks completion for one cycle.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int d_width = 8,
  parameter int a_width = 8,
  parameter int lines   = 4,
  parameter int ram_lat = 2
) (
  input  logic               g_clk,
  input  logic               g_clr,
  input  logic [a_width-1:0] cpu_addr,
  input  logic [d_width-1:0] cpu_wdata,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  input  logic               flush,
  output logic [d_width-1:0] cpu_rdata,
  output logic               odv,
  output logic [a_width-1:0] ram_addr,
  output logic [d_width-1:0] ram_wdata,
  output logic               ram_rd,
  output logic               ram_wr,
  input  logic [d_width-1:0] ram_rdata,
  output state_t             o_dbg_state
);

  localparam int IW = idx_w(lines);
  localparam int TW = tag_w(a_width, lines);
  localparam int CW = $clog2(ram_lat + 1);

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic [a_width-1:0] r_addr, w_addr;
  logic [d_width-1:0] r_wdata, w_wdata;
  logic               r_ram_rd, w_ram_rd, r_ram_wr, w_ram_wr;

  logic [IW-1:0]      w_idx, w_wr_idx;
  logic [TW-1:0]      w_tag, w_wr_tag, w_st_tag;
  logic [d_width-1:0] w_st_data, w_wr_data;
  logic               w_st_valid, w_hit, w_we, w_clear;

  assign w_idx = cpu_addr[IW-1:0];
  assign w_tag = cpu_addr[a_width-1:IW];
  assign w_hit = w_st_valid && (w_st_tag == w_tag);

  dcache_store #(.d_width(d_width), .a_width(a_width), .lines(lines)) u_store (
    .i_clk     (g_clk),
    .i_clr     (g_clr),
    .i_clear   (w_clear),
    .i_rd_idx  (w_idx),
    .o_valid   (w_st_valid),
    .o_tag     (w_st_tag),
    .o_data    (w_st_data),
    .i_we      (w_we),
    .i_wr_idx  (w_wr_idx),
    .i_wr_tag  (w_wr_tag),
    .i_wr_data (w_wr_data)
  );

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_ram_rd <= 1'b0;
      r_ram_wr <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_ram_rd <= w_ram_rd;
      r_ram_wr <= w_ram_wr;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt     = r_cnt;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_ram_rd  = r_ram_rd;
    w_ram_wr  = r_ram_wr;
    w_we      = 1'b0;
    w_clear   = 1'b0;
    w_wr_idx  = w_idx;
    w_wr_tag  = w_tag;
    w_wr_data = cpu_wdata;
    odv       = 1'b0;
    cpu_rdata = '0;
    case (r_state)
      IDLE: begin
        if (flush) begin
          w_clear = 1'b1;
        end else if (cpu_wr) begin
          w_addr   = cpu_addr;
          w_wdata  = cpu_wdata;
          w_we     = w_hit;
          w_cnt    = CW'(ram_lat);
          w_ram_wr = 1'b1;
          w_next   = WRITE;
        end else if (cpu_rd) begin
          if (w_hit) begin
            odv       = 1'b1;
            cpu_rdata = w_st_data;
          end else begin
            w_addr   = cpu_addr;
            w_cnt    = CW'(ram_lat);
            w_ram_rd = 1'b1;
            w_next   = RFILL;
          end
        end else begin
          odv = 1'b1;
        end
      end
      RFILL: begin
        w_cnt = r_cnt - CW'(1);
        // Fill lands on the last RAM cycle so the next IDLE cycle is a hit.
        if (r_cnt == CW'(1)) begin
          w_we      = 1'b1;
          w_wr_idx  = r_addr[IW-1:0];
          w_wr_tag  = r_addr[a_width-1:IW];
          w_wr_data = ram_rdata;
          w_ram_rd  = 1'b0;
          w_next    = IDLE;
        end
      end
      WRITE: begin
        w_cnt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_ram_wr = 1'b0;
          w_next   = WDONE;
        end
      end
      WDONE: begin
        odv    = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign ram_addr    = r_addr;
  assign ram_wdata   = r_wdata;
  assign ram_rd      = r_ram_rd;
  assign ram_wr      = r_ram_wr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: RAM model, reference cache model and a read/write scoreboard.
module tb_dcache_ctrl;

  localparam int RAM_LAT = 2;

  logic       g_clk = 1'b0;
  logic       g_clr;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, ram_addr, ram_wdata, ram_rdata;
  logic       cpu_rd, cpu_wr, flush, odv, ram_rd, ram_wr;
  logic [1:0] dbg_state;

  dcache_ctrl #(.d_width(8), .a_width(8), .lines(4), .ram_lat(RAM_LAT)) dut (
    .g_clk       (g_clk),
    .g_clr       (g_clr),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .flush       (flush),
    .cpu_rdata   (cpu_rdata),
    .odv         (odv),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rd      (ram_rd),
    .ram_wr      (ram_wr),
    .ram_rdata   (ram_rdata),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 g_clk = ~g_clk;

  // RAM model: unwritten locations return a fixed pattern
  bit [7:0] ram_mem [256];
  bit       ram_wv  [256];

  function automatic logic [7:0] ram_init(input logic [7:0] a);
    return (a == 8'h13) ? 8'h5A : (a ^ 8'hA5);
  endfunction

  assign ram_rdata = !ram_rd ? 8'h00 :
                     (ram_wv[ram_addr] ? ram_mem[ram_addr] : ram_init(ram_addr));

  always @(posedge g_clk) begin
    if (ram_wr) begin
      ram_mem[ram_addr] <= ram_wdata;
      ram_wv[ram_addr]  <= 1'b1;
    end
  end

  // reference model and scoreboard
  logic [7:0] ref_mem [256];
  logic       ref_valid [4];
  logic [5:0] ref_tag [4];
  logic [7:0] exp_q[$];
  logic [7:0] wexp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp_v, $time);
    end
  endtask

  function automatic logic ref_hit(input logic [7:0] a);
    return ref_valid[a[1:0]] && (ref_tag[a[1:0]] == a[7:2]);
  endfunction

  task automatic clear_ref();
    for (int i = 0; i < 4; i++) ref_valid[i] = 1'b0;
  endtask

  // driver tasks: entered and left at posedge+1
  task automatic do_read(input logic [7:0] a);
    logic hit;
    int   n, nrd;
    hit = ref_hit(a);
    exp_q.push_back(ref_mem[a]);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    n = 0; nrd = 0;
    forever begin
      @(negedge g_clk);
      if (odv) break;
      if (ram_rd) begin
        nrd++;
        chk("rfill_addr", ram_addr, a);
      end
      if (ram_wr) chk("rd_no_ram_wr", ram_wr, 0);
      if (n >= 20) break;
      @(posedge g_clk); #1;
      n++;
    end
    chk("rd_latency", n, hit ? 0 : RAM_LAT + 1);
    chk("rd_strobes", nrd, hit ? 0 : RAM_LAT);
    chk("rd_data", cpu_rdata, exp_q.pop_front());
    ref_valid[a[1:0]] = 1'b1;
    ref_tag[a[1:0]]   = a[7:2];
    @(posedge g_clk); #1;
    cpu_rd = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic also_rd);
    int n, nwr, nrd;
    wexp_q.push_back(d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    cpu_rd    = also_rd;
    n = 0; nwr = 0; nrd = 0;
    forever begin
      @(negedge g_clk);
      if (odv) break;
      if (ram_wr) begin
        nwr++;
        chk("wr_addr", ram_addr, a);
        chk("wr_data", ram_wdata, wexp_q[0]);
      end
      if (ram_rd) nrd++;
      if (n >= 20) break;
      @(posedge g_clk); #1;
      n++;
    end
    chk("wr_latency", n, RAM_LAT + 1);
    chk("wr_strobes", nwr, RAM_LAT);
    chk("wr_no_ram_rd", nrd, 0);
    void'(wexp_q.pop_front());
    ref_mem[a] = d;
    @(posedge g_clk); #1;
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    @(negedge g_clk);
    chk("wdone_one_cycle", dbg_state, 0);
    @(posedge g_clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = ram_init(8'(i));
    clear_ref();
    g_clr = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; flush = 1'b0;
    repeat (2) @(posedge g_clk);
    #1 g_clr = 1'b0;
    @(negedge g_clk);
    chk("rst_odv", odv, 1);
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge g_clk); #1;

    // cold miss, hit, write-hit coherence
    do_read(8'h13);
    do_read(8'h13);
    do_write(8'h13, 8'hC3, 1'b0);
    do_read(8'h13);

    // conflict eviction and no write-allocate
    do_read(8'h01);
    do_read(8'h05);
    do_read(8'h01);
    do_write(8'h22, 8'h77, 1'b0);
    do_read(8'h22);

    // flush with a simultaneous read of a cached line
    cpu_addr = 8'h01; cpu_rd = 1'b1; flush = 1'b1;
    @(negedge g_clk);
    chk("flush_odv", odv, 0);
    @(posedge g_clk); #1;
    flush = 1'b0; cpu_rd = 1'b0;
    clear_ref();
    @(negedge g_clk);
    chk("flush_no_ram_rd", ram_rd, 0);
    chk("flush_no_ram_wr", ram_wr, 0);
    chk("flush_state", dbg_state, 0);
    @(posedge g_clk); #1;
    do_read(8'h01);

    // read and write together: write wins
    do_write(8'h05, 8'h99, 1'b1);
    do_read(8'h05);

    // reset during a read miss
    cpu_addr = 8'hF3; cpu_rd = 1'b1;
    @(posedge g_clk); #1;
    g_clr = 1'b1; cpu_rd = 1'b0;
    @(negedge g_clk);
    chk("midmiss_ram_rd_before", ram_rd, 1);
    @(posedge g_clk); #1;
    g_clr = 1'b0;
    clear_ref();
    @(negedge g_clk);
    chk("midmiss_ram_rd", ram_rd, 0);
    chk("midmiss_state", dbg_state, 0);
    chk("midmiss_ram_addr", ram_addr, 0);
    @(posedge g_clk); #1;
    do_read(8'h13);
    do_read(8'hF3);

    // random mix over a few tags per index
    for (int k = 0; k < 30; k++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) do_write(a, 8'($urandom_range(0, 255)), 1'b0);
      else                           do_read(a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
